// File: rtl/ysyx_220053_div_pkg.sv
// Shared encodings and operand/result helpers for the divide sequencer.
// Only a 64-bit datapath is supported, so the helpers are fixed at 64 bits.
package ysyx_220053_div_pkg;

   localparam logic [1:0] DIV_OP_DIV  = 2'd0;
   localparam logic [1:0] DIV_OP_DIVU = 2'd1;
   localparam logic [1:0] DIV_OP_REM  = 2'd2;
   localparam logic [1:0] DIV_OP_REMU = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } div_state_e;

   localparam logic [63:0] XLEN_MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] XLEN_MIN32 = 64'hFFFF_FFFF_8000_0000;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   endfunction

   // REM and REMU share the upper encoding bit.
   function automatic logic op_is_rem(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic [63:0] extend_operand(input logic [63:0] value,
                                                  input logic        word,
                                                  input logic        sgn);
      logic [63:0] ext;
      ext = value;
      if (word) begin
         ext = sgn ? {{32{value[31]}}, value[31:0]} : {32'b0, value[31:0]};
      end
      return ext;
   endfunction

   function automatic logic [63:0] format_result(input logic [63:0] value,
                                                 input logic        word);
      return word ? {{32{value[31]}}, value[31:0]} : value;
   endfunction

endpackage

// File: rtl/ysyx_220053_div_special.sv
// Fast-path detection for divide-by-zero and signed overflow on the
// already-extended operands; produces the architectural quotient/remainder.
module ysyx_220053_div_special
   import ysyx_220053_div_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            is_signed,
   input  logic            is_word,
   output logic            is_special,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic            div_zero;
   logic            overflow;
   logic [XLEN-1:0] min_val;

   always_comb begin
      min_val    = is_word ? XLEN_MIN32 : XLEN_MIN64;
      div_zero   = (divisor == '0);
      // W operands are sign-extended already, so -1 is all ones in both widths.
      overflow   = is_signed && (divisor == '1) && (dividend == min_val);
      is_special = div_zero || overflow;
      quotient   = div_zero ? '1 : dividend;
      remainder  = div_zero ? dividend : '0;
   end

endmodule

// File: rtl/ysyx_220053_div_ctrl.sv
// Sequencer between the EXU and the iterative divider: operand prep,
// fast-path special cases, divider handshake and a one-entry result buffer.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_ISSUE | div_valid held until the divider takes the operands
// ST_WAIT  | waiting for the divider completion pulse
// ST_RESP  | buffered result offered to writeback
module ysyx_220053_div_ctrl
   import ysyx_220053_div_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic            req_word,
   input  logic [TAGW-1:0] req_tag,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic [TAGW-1:0] resp_tag,
   output logic            busy,
   output logic            div_valid,
   input  logic            div_ready,
   output logic            div_signed,
   output logic            div_flush,
   output logic [XLEN-1:0] div_dividend,
   output logic [XLEN-1:0] div_divisor,
   input  logic            div_out_valid,
   input  logic [XLEN-1:0] div_quotient,
   input  logic [XLEN-1:0] div_remainder
);

   div_state_e      state;
   div_state_e      state_nxt;

   logic            req_signed;
   logic [XLEN-1:0] ext_dividend;
   logic [XLEN-1:0] ext_divisor;
   logic            sp_hit;
   logic [XLEN-1:0] sp_quotient;
   logic [XLEN-1:0] sp_remainder;
   logic [XLEN-1:0] sp_sel;
   logic [XLEN-1:0] div_sel;
   logic            accept;
   logic            div_done;

   logic            signed_q;
   logic            rem_q;
   logic            word_q;
   logic [TAGW-1:0] tag_q;
   logic [XLEN-1:0] dividend_q;
   logic [XLEN-1:0] divisor_q;
   logic [XLEN-1:0] result_q;

   assign req_signed   = op_is_signed(req_op);
   assign ext_dividend = extend_operand(src1, req_word, req_signed);
   assign ext_divisor  = extend_operand(src2, req_word, req_signed);

   ysyx_220053_div_special #(
      .XLEN (XLEN)
   ) u_special (
      .dividend   (ext_dividend),
      .divisor    (ext_divisor),
      .is_signed  (req_signed),
      .is_word    (req_word),
      .is_special (sp_hit),
      .quotient   (sp_quotient),
      .remainder  (sp_remainder)
   );

   assign accept   = (state == ST_IDLE) && req_valid && !flush;
   assign div_done = (state == ST_WAIT) && div_out_valid && !flush;
   assign sp_sel   = op_is_rem(req_op) ? sp_remainder : sp_quotient;
   assign div_sel  = rem_q ? div_remainder : div_quotient;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      div_valid  = 1'b0;
      div_flush  = 1'b0;
      busy       = 1'b1;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (accept) begin
               state_nxt = sp_hit ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            div_valid = 1'b1;
            div_flush = flush;
            if (div_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            div_flush = flush;
            if (div_out_valid) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      // Flush wins over every other transition, including the writeback handshake.
      if (flush) begin
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         signed_q   <= 1'b0;
         rem_q      <= 1'b0;
         word_q     <= 1'b0;
         tag_q      <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         result_q   <= '0;
      end else if (accept) begin
         signed_q   <= req_signed;
         rem_q      <= op_is_rem(req_op);
         word_q     <= req_word;
         tag_q      <= req_tag;
         dividend_q <= ext_dividend;
         divisor_q  <= ext_divisor;
         // W fast-path results get the same bit-31 extension as divider results.
         if (sp_hit) begin
            result_q <= format_result(sp_sel, req_word);
         end
      end else if (div_done) begin
         result_q <= format_result(div_sel, word_q);
      end
   end

   assign resp_data    = result_q;
   assign resp_tag     = tag_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   assign div_signed   = signed_q;

endmodule

// File: tb/tb_ysyx_220053_div_ctrl.sv
// Self-checking bench for the divide sequencer with a behavioural divider
// and an arithmetic RV64M reference model.
module tb_ysyx_220053_div_ctrl;
   import ysyx_220053_div_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic        req_word;
   logic [4:0]  req_tag;
   logic [63:0] src1;
   logic [63:0] src2;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic [4:0]  resp_tag;
   logic        busy;
   logic        div_valid;
   logic        div_ready;
   logic        div_signed;
   logic        div_flush;
   logic [63:0] div_dividend;
   logic [63:0] div_divisor;
   logic        div_out_valid;
   logic [63:0] div_quotient;
   logic [63:0] div_remainder;

   int n_tests = 0;
   int n_fail  = 0;
   int div_lat = 3;

   always #5 clk = ~clk;

   ysyx_220053_div_ctrl #(.XLEN(64), .TAGW(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_word      (req_word),
      .req_tag       (req_tag),
      .src1          (src1),
      .src2          (src2),
      .flush         (flush),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_tag      (resp_tag),
      .busy          (busy),
      .div_valid     (div_valid),
      .div_ready     (div_ready),
      .div_signed    (div_signed),
      .div_flush     (div_flush),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_out_valid (div_out_valid),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder)
   );

   // Behavioural divider: samples handshakes just before each rising edge,
   // drives its outputs just after it.
   initial begin : divider_model
      logic        m_busy;
      int          m_cnt;
      logic [63:0] m_q;
      logic [63:0] m_r;
      m_busy = 1'b0;
      m_cnt = 0;
      m_q = '0;
      m_r = '0;
      div_ready = 1'b0;
      div_out_valid = 1'b0;
      div_quotient = '0;
      div_remainder = '0;
      forever begin
         @(negedge clk);
         #4;
         if (!rst || div_flush) begin
            m_busy = 1'b0;
         end else if (div_valid && div_ready) begin
            m_busy = 1'b1;
            m_cnt = div_lat;
            if (div_signed) begin
               m_q = $signed(div_dividend) / $signed(div_divisor);
               m_r = $signed(div_dividend) % $signed(div_divisor);
            end else begin
               m_q = div_dividend / div_divisor;
               m_r = div_dividend % div_divisor;
            end
         end
         @(posedge clk);
         #1;
         div_out_valid = 1'b0;
         if (m_busy && rst) begin
            if (m_cnt == 0) begin
               div_out_valid = 1'b1;
               div_quotient = m_q;
               div_remainder = m_r;
               m_busy = 1'b0;
            end else begin
               m_cnt = m_cnt - 1;
            end
         end
         div_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ext_op(input logic [63:0] v, input logic word, input logic sgn);
      if (!word) return v;
      if (sgn) return {{32{v[31]}}, v[31:0]};
      return {32'b0, v[31:0]};
   endfunction

   // RV64M result computed directly from the ISA rules in the operation's own width.
   function automatic logic [63:0] ref_res(input logic [1:0] op, input logic word,
                                           input logic [63:0] a, input logic [63:0] b);
      logic rem;
      logic sgn;
      rem = op[1];
      sgn = (op == 2'd0) || (op == 2'd2);
      if (word) begin
         int          sx, sy, sq, sr;
         int unsigned ux, uy, uq, ur;
         logic [31:0] r32;
         if (sgn) begin
            sx = a[31:0];
            sy = b[31:0];
            if (sy == 0) begin sq = -1; sr = sx; end
            else if (sx == 32'sh8000_0000 && sy == -1) begin sq = sx; sr = 0; end
            else begin sq = sx / sy; sr = sx % sy; end
            r32 = rem ? sr : sq;
         end else begin
            ux = a[31:0];
            uy = b[31:0];
            if (uy == 0) begin uq = 32'hFFFF_FFFF; ur = ux; end
            else begin uq = ux / uy; ur = ux % uy; end
            r32 = rem ? ur : uq;
         end
         return {{32{r32[31]}}, r32};
      end else begin
         longint          lx, ly, lq, lr;
         longint unsigned vx, vy, vq, vr;
         if (sgn) begin
            lx = a;
            ly = b;
            if (ly == 0) begin lq = -1; lr = lx; end
            else if (lx == 64'sh8000_0000_0000_0000 && ly == -1) begin lq = lx; lr = 0; end
            else begin lq = lx / ly; lr = lx % ly; end
            return rem ? lr : lq;
         end else begin
            vx = a;
            vy = b;
            if (vy == 0) begin vq = '1; vr = vx; end
            else begin vq = vx / vy; vr = vx % vy; end
            return rem ? vr : vq;
         end
      end
   endfunction

   function automatic logic [63:0] pick_operand();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0: v = '0;
         1: v = 64'($signed($urandom_range(0, 100)) - 50);
         2: v = {$urandom, $urandom};
         3: v = '1;
         4: v = ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
         default: v = {32'b0, $urandom};
      endcase
      return v;
   endfunction

   task automatic start_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag);
      @(negedge clk);
      req_valid = 1'b1;
      req_op = op;
      req_word = word;
      req_tag = tag;
      src1 = a;
      src2 = b;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                         input logic [63:0] want, input int hold);
      logic        sgn;
      logic        spec;
      logic [63:0] ea, eb;
      int          n;
      sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
      ea = ext_op(a, word, sgn);
      eb = ext_op(b, word, sgn);
      spec = (eb == 64'd0) ||
             (sgn && eb == '1 && ea == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      check({name, ".req_ready"}, 64'(req_ready), 64'd1);
      start_op(op, word, a, b, tag);
      if (spec) begin
         check({name, ".fast_resp_valid"}, 64'(resp_valid), 64'd1);
         check({name, ".fast_div_valid"}, 64'(div_valid), 64'd0);
      end else begin
         check({name, ".div_valid"}, 64'(div_valid), 64'd1);
         check({name, ".div_dividend"}, div_dividend, ea);
         check({name, ".div_divisor"}, div_divisor, eb);
         check({name, ".div_signed"}, 64'(div_signed), 64'(sgn));
         check({name, ".early_resp"}, 64'(resp_valid), 64'd0);
      end
      n = 0;
      while (!resp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({name, ".resp_arrived"}, 64'(resp_valid), 64'd1);
      for (int i = 0; i < hold; i++) begin
         check({name, ".hold_data"}, resp_data, want);
         check({name, ".hold_tag"}, 64'(resp_tag), 64'(tag));
         check({name, ".hold_req_ready"}, 64'(req_ready), 64'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      check({name, ".resp_data"}, resp_data, want);
      check({name, ".resp_tag"}, 64'(resp_tag), 64'(tag));
      @(negedge clk);
      resp_ready = 1'b0;
      check({name, ".idle_after"}, {62'd0, resp_valid, req_ready}, 64'd1);
   endtask

   task automatic wait_for_wait_state(input string name);
      int n;
      n = 0;
      while (!(busy && !div_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, ".reached_wait"}, {62'd0, busy, div_valid}, 64'd2);
   endtask

   logic [1:0]  r_op;
   logic        r_word;
   logic [63:0] r_a, r_b;
   logic [4:0]  r_tag;
   int          stale;

   initial begin : stimulus
      rst = 1'b0;
      req_valid = 1'b0;
      req_op = '0;
      req_word = 1'b0;
      req_tag = '0;
      src1 = '0;
      src2 = '0;
      flush = 1'b0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.req_ready", 64'(req_ready), 64'd1);
      check("reset.flags", {60'd0, resp_valid, div_valid, div_flush, busy}, 64'd0);
      check("reset.resp_data", resp_data, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      run_op("div_neg", DIV_OP_DIV, 1'b0, -64'sd20, 64'd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFFA, 0);
      run_op("rem_neg", DIV_OP_REM, 1'b0, -64'sd20, 64'd3, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      run_op("divu_z", DIV_OP_DIVU, 1'b0, 64'h1234, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op("remu_z", DIV_OP_REMU, 1'b0, 64'h1234, 64'd0, 5'd4, 64'h1234, 0);
      run_op("divw_ovf", DIV_OP_DIV, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd5,
             64'hFFFF_FFFF_8000_0000, 0);
      run_op("remw_ovf", DIV_OP_REM, 1'b1, 64'h0000_0000_8000_0000, '1, 5'd6, 64'd0, 0);
      run_op("divuw", DIV_OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'd7,
             64'h0000_0000_7FFF_FFFF, 0);
      run_op("div_ovf64", DIV_OP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd8,
             64'h8000_0000_0000_0000, 0);
      run_op("hold5", DIV_OP_DIVU, 1'b0, 64'd1000, 64'd7, 5'd9, 64'd142, 5);

      // Request presented together with flush in IDLE must be dropped.
      @(negedge clk);
      req_valid = 1'b1;
      flush = 1'b1;
      src1 = 64'd9;
      src2 = 64'd3;
      @(negedge clk);
      req_valid = 1'b0;
      flush = 1'b0;
      check("idle_flush.busy", 64'(busy), 64'd0);

      // Flush ten cycles into WAIT.
      div_lat = 40;
      start_op(DIV_OP_DIV, 1'b0, 64'd100, 64'd7, 5'd10);
      wait_for_wait_state("flush_wait");
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_wait.div_flush", 64'(div_flush), 64'd1);
      @(negedge clk);
      flush = 1'b0;
      check("flush_wait.busy_after", 64'(busy), 64'd0);
      stale = 0;
      repeat (60) begin
         @(negedge clk);
         if (resp_valid) stale++;
      end
      check("flush_wait.stale_resp", 64'(stale), 64'd0);
      div_lat = 3;
      run_op("after_flush", DIV_OP_DIV, 1'b0, 64'd7, 64'd2, 5'd11, 64'd3, 0);

      // Flush while a fast-path result is buffered.
      start_op(DIV_OP_DIVU, 1'b0, 64'd5, 64'd0, 5'd12);
      check("flush_resp.resp_valid", 64'(resp_valid), 64'd1);
      flush = 1'b1;
      #1;
      check("flush_resp.div_flush", 64'(div_flush), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      check("flush_resp.dropped", {62'd0, resp_valid, busy}, 64'd0);

      for (int k = 0; k < 40; k++) begin
         r_op = 2'($urandom_range(0, 3));
         r_word = 1'($urandom_range(0, 1));
         r_a = pick_operand();
         r_b = pick_operand();
         r_tag = 5'($urandom);
         div_lat = $urandom_range(0, 8);
         run_op($sformatf("rand%0d", k), r_op, r_word, r_a, r_b, r_tag,
                ref_res(r_op, r_word, r_a, r_b), $urandom_range(0, 3));
      end

      // Asynchronous reset in the middle of WAIT.
      div_lat = 40;
      start_op(DIV_OP_REMU, 1'b0, 64'd77, 64'd5, 5'd13);
      wait_for_wait_state("rst_wait");
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst.req_ready", 64'(req_ready), 64'd1);
      check("async_rst.flags", {60'd0, resp_valid, div_valid, div_flush, busy}, 64'd0);
      check("async_rst.resp_data", resp_data, 64'd0);
      check("async_rst.resp_tag", 64'(resp_tag), 64'd0);
      check("async_rst.div_dividend", div_dividend, 64'd0);
      check("async_rst.div_divisor", div_divisor, 64'd0);
      check("async_rst.div_signed", 64'(div_signed), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      div_lat = 2;
      @(negedge clk);
      run_op("post_rst", DIV_OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd4, 5'd14,
             64'hFFFF_FFFF_FFFF_FFFD, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_220053_div_ctrl.md
# ysyx_220053_div_ctrl

Sequencer between the EXU and the 64-bit iterative divider `ysyx_220053_divu`. It accepts one RV64M divide/remainder request at a time and prepares operands, including 32-bit W-variant extension. Divide-by-zero and signed overflow are resolved in a fast path that bypasses the divider. The block drives the divider handshake, captures its one-cycle result pulse, selects and formats the result, and holds it in a one-entry buffer until writeback takes it. A pipeline flush aborts everything in flight.

## Interface
- Parameters:
- `XLEN`, 64: datapath width. Only 64 is supported.
- `TAGW`, 5: destination-register tag width.
- Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, **asynchronous, active-low**.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_op` in 2: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- `req_word` in 1: W variant (DIVW/DIVUW/REMW/REMUW).
- `req_tag` in TAGW: destination tag.
- `src1`, `src2` in XLEN: dividend and divisor.
- `flush` in 1: abort the current operation.
- `resp_valid` out 1 / `resp_ready` in 1: response handshake.
- `resp_data` out XLEN: result value.
- `resp_tag` out TAGW: tag of the result.
- `busy` out 1: high in any state other than IDLE.
- `div_valid` out 1 / `div_ready` in 1: divider request handshake.
- `div_signed` out 1: signed-divide select to the divider.
- `div_flush` out 1: divider abort.
- `div_dividend`, `div_divisor` out XLEN: operands to the divider.
- `div_out_valid` in 1: divider completion pulse.
- `div_quotient`, `div_remainder` in XLEN: divider results.

## Operation
- States:
- IDLE: `req_ready`=1; nothing else is asserted.
- ISSUE: `div_valid`=1.
- WAIT: waiting for the divider's completion pulse.
- RESP: `resp_valid`=1.
- Accepting a request (IDLE and `req_valid` and not `flush`):
- Latch op, word, tag and the extended operands.
- W signed operands: sign-extend bit 31. W unsigned operands: zero-extend bits 31:0.
- Signed means op 0 or 2.
- Special cases, evaluated on the extended operands at accept time:
- Divisor zero: quotient = all ones; remainder = extended dividend.
- Signed, dividend = most-negative value of the active width, divisor = −1: quotient = dividend; remainder = 0.
- Special case → RESP directly, with the result buffered. Otherwise → ISSUE.
- ISSUE: hold operands and `div_signed` stable. When `div_ready` is high the divider takes the request that cycle → WAIT.
- WAIT: on `div_out_valid`, capture the quotient (DIV/DIVU) or the remainder (REM/REMU) → RESP.
- W ops: result = sign-extend of bit 31 of the selected value.
- The divider output pulse is exactly one cycle. It is never missed, because the block is always in WAIT when the pulse arrives.
- RESP: hold `resp_data` and `resp_tag` stable. On `resp_ready` → IDLE. A new request is accepted no earlier than the cycle after the response handshake.
- `flush` is honoured in every state:
- Next state is IDLE; any buffered response is discarded.
- `div_flush` = `flush` & (state is ISSUE or WAIT), combinationally.
- In RESP, flush overrides `resp_ready`.
- `req_valid` together with `flush` in IDLE is not accepted.
- A `div_out_valid` arriving in the same cycle as `flush` is ignored.
- Reset (asynchronous, `rst`=0):
- State = IDLE; result buffer and latched fields = 0.
- Output values: `req_ready`=1, and `resp_valid`, `div_valid`, `div_flush`, `busy` all 0.
- `resp_data`, `resp_tag`, `div_dividend`, `div_divisor` and `div_signed` are driven from registers, so all read 0.

## Timing
- `req_ready` is combinational from state only, never from `req_valid`.
- `resp_valid` comes straight from the state register.
- Special-case latency: accepted at cycle T → `resp_valid` at T+1.
- Normal latency:
- Accepted at T → `div_valid` at T+1.
- Divider handshake at the first cycle ≥ T+1 in which `div_ready` is high.
- `resp_valid` one cycle after `div_out_valid`.
- With the present divider this is 68 cycles from accept to `resp_valid`.
- No combinational path from `div_quotient` or `div_remainder` to `resp_data`: the result is registered.
- Back-to-back throughput: one request per (latency + 1) cycles when `resp_ready` is held high.

## Structure
- Package `ysyx_220053_div_pkg` holds:
- Op encodings (`DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`).
- The state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
- Constants `XLEN_MIN64` = 64'h8000_0000_0000_0000 and `XLEN_MIN32` = 64'hFFFF_FFFF_8000_0000.
- Sub-module `ysyx_220053_div_special`, purely combinational:
- Inputs: extended operands, signed flag, word flag.
- Outputs: `is_special` plus the fast-path quotient and remainder.
- The controller instantiates it once; the divider is instantiated by the parent, not inside this block.

## Test plan
- DIV, src1=−20, src2=3 → `div_valid` at T+1; `resp_data`=−6 (0xFFFF_FFFF_FFFF_FFFA). REM of the same operands → −2.
- DIVU, src2=0, src1=0x1234 → `resp_valid` at T+1 with 0xFFFF_FFFF_FFFF_FFFF; `div_valid` never rises. REMU of the same operands → 0x1234.
- DIVW, src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF → fast path, `resp_data`=0xFFFF_FFFF_8000_0000. REMW of the same operands → 0.
- DIVUW, src1=0xFFFF_FFFF_FFFF_FFFE, src2=2 → divider operands 0xFFFF_FFFE and 2 with `div_signed`=0; `resp_data`=0x0000_0000_7FFF_FFFF.
- `flush` 10 cycles into WAIT → `div_flush`=1 that cycle; `busy`=0 next cycle; a new DIV 7/2 then returns 3, and no stale response appears.
- `resp_ready` held low for 5 cycles in RESP → `resp_data`/`resp_tag` stable and `req_ready`=0. Async `rst` asserted mid-WAIT → all outputs at their reset values immediately, with no clock edge needed.
